// File: rtl/hdlc_rx_monitor.sv
// Multi-channel HDLC Rx runtime monitor: flag/abort latency, idle level, optional overflow check.
// Define HDLC_MON_OVERFLOW_CHK_EN to build the Rx_Overflow && Rx_WrBuff check.
module hdlc_rx_monitor #(
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_LAT = 1,
  parameter int unsigned IDLE_LEN  = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Clear,
  input  logic [CHANNELS-1:0] Rx,
  input  logic [CHANNELS-1:0] Rx_FlagDetect,
  input  logic [CHANNELS-1:0] Rx_ValidFrame,
  input  logic [CHANNELS-1:0] Rx_AbortDetect,
  input  logic [CHANNELS-1:0] Rx_AbortSignal,
  input  logic [CHANNELS-1:0] Rx_Overflow,
  input  logic [CHANNELS-1:0] Rx_WrBuff,
  input  logic [CHANNELS-1:0] TxEN,
  input  logic [CHANNELS-1:0] RxEN,
  output logic [CHANNELS-1:0] FlagErr,
  output logic [CHANNELS-1:0] AbortErr,
  output logic [CHANNELS-1:0] IdleErr,
  output logic [CHANNELS-1:0] OvfErr,
  output logic                ErrPulse,
  output logic [CNT_W-1:0]    ErrCnt
);

  localparam int unsigned IncW = $clog2(4 * CHANNELS + 1);
  localparam int unsigned SumW = ((CNT_W > IncW) ? CNT_W : IncW) + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CHANNELS-1:0]   flagViol;
  logic [CHANNELS-1:0]   abortViol;
  logic [CHANNELS-1:0]   idleViol;
  logic [CHANNELS-1:0]   ovfViol;
  logic [4*CHANNELS-1:0] allViol;
  logic [IncW-1:0]       violInc;
  logic [CNT_W-1:0]      cntBase;
  logic [SumW-1:0]       cntSum;
  logic [CNT_W-1:0]      cntNext;

  for (genvar c = 0; c < CHANNELS; c++) begin : gCh
    logic [6:0]           hist;
    logic [FLAG_LAT-1:0]  flagPend;
    logic [ABORT_LAT-1:0] abortPend;
    logic [7:0]           idleCnt;
    logic                 flagMatch;
    logic                 abortQual;
    logic                 idle;

    // All-ones history reset means a flag can only match after a real leading 0.
    assign flagMatch = ({hist, Rx[c]} == 8'h7E);
    assign abortQual = Rx_AbortDetect[c] & Rx_ValidFrame[c];
    assign idle      = ~TxEN[c] & ~RxEN[c];

    always_ff @(posedge Clk) begin
      if (Rst) begin
        hist      <= 7'h7F;
        flagPend  <= '0;
        abortPend <= '0;
        idleCnt   <= '0;
      end else begin
        hist      <= {hist[5:0], Rx[c]};
        flagPend  <= FLAG_LAT'({flagPend, flagMatch});
        abortPend <= ABORT_LAT'({abortPend, abortQual});
        if (!idle) begin
          idleCnt <= '0;
        end else if (idleCnt != 8'hFF) begin
          idleCnt <= idleCnt + 8'd1;
        end
      end
    end

    assign flagViol[c]  = flagPend[FLAG_LAT-1] & ~Rx_FlagDetect[c];
    assign abortViol[c] = abortPend[ABORT_LAT-1] & ~Rx_AbortSignal[c];
    assign idleViol[c]  = (idleCnt >= 8'(IDLE_LEN)) & idle & ~Rx[c];
  end

`ifdef HDLC_MON_OVERFLOW_CHK_EN
  assign ovfViol = Rx_Overflow & Rx_WrBuff;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      OvfErr <= '0;
    end else if (Clear) begin
      OvfErr <= ovfViol;
    end else begin
      OvfErr <= OvfErr | ovfViol;
    end
  end
`else
  logic unusedOvf;
  assign unusedOvf = ^{Rx_Overflow, Rx_WrBuff};
  assign ovfViol   = '0;
  assign OvfErr    = '0;
`endif

  assign allViol = {ovfViol, idleViol, abortViol, flagViol};
  assign violInc = IncW'($countones(allViol));
  assign cntBase = Clear ? '0 : ErrCnt;
  assign cntSum  = SumW'(cntBase) + SumW'(violInc);
  assign cntNext = (cntSum > SumW'(CntMax)) ? CntMax : CNT_W'(cntSum);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      FlagErr  <= '0;
      AbortErr <= '0;
      IdleErr  <= '0;
      ErrPulse <= 1'b0;
      ErrCnt   <= '0;
    end else begin
      // Clear restarts the sticky bits from this edge's violations rather than dropping them.
      if (Clear) begin
        FlagErr  <= flagViol;
        AbortErr <= abortViol;
        IdleErr  <= idleViol;
      end else begin
        FlagErr  <= FlagErr | flagViol;
        AbortErr <= AbortErr | abortViol;
        IdleErr  <= IdleErr | idleViol;
      end
      ErrPulse <= |allViol;
      ErrCnt   <= cntNext;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Scoreboard bench for hdlc_rx_monitor: expectations are queued with the cycle they apply to and
// a negedge monitor compares them against the registered outputs.
module tb_hdlc_rx_monitor;

  localparam int CH = 4;

`ifdef HDLC_MON_OVERFLOW_CHK_EN
  localparam logic [3:0] OvfExp    = 4'h4;
  localparam logic [2:0] CntAftOvf = 3'd2;
  localparam logic       PulseOvf  = 1'b1;
`else
  localparam logic [3:0] OvfExp    = 4'h0;
  localparam logic [2:0] CntAftOvf = 3'd1;
  localparam logic       PulseOvf  = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Clear = 1'b0;
  logic [CH-1:0] Rx = '1;
  logic [CH-1:0] Rx_FlagDetect = '0;
  logic [CH-1:0] Rx_ValidFrame = '0;
  logic [CH-1:0] Rx_AbortDetect = '0;
  logic [CH-1:0] Rx_AbortSignal = '0;
  logic [CH-1:0] Rx_Overflow = '0;
  logic [CH-1:0] Rx_WrBuff = '0;
  logic [CH-1:0] TxEN = '0;
  logic [CH-1:0] RxEN = '1;
  logic [CH-1:0] FlagErr;
  logic [CH-1:0] AbortErr;
  logic [CH-1:0] IdleErr;
  logic [CH-1:0] OvfErr;
  logic          ErrPulse;
  logic [2:0]    ErrCnt;

  hdlc_rx_monitor #(
    .CHANNELS (CH),
    .FLAG_LAT (2),
    .ABORT_LAT(1),
    .IDLE_LEN (8),
    .CNT_W    (3)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Clear         (Clear),
    .Rx            (Rx),
    .Rx_FlagDetect (Rx_FlagDetect),
    .Rx_ValidFrame (Rx_ValidFrame),
    .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_Overflow   (Rx_Overflow),
    .Rx_WrBuff     (Rx_WrBuff),
    .TxEN          (TxEN),
    .RxEN          (RxEN),
    .FlagErr       (FlagErr),
    .AbortErr      (AbortErr),
    .IdleErr       (IdleErr),
    .OvfErr        (OvfErr),
    .ErrPulse      (ErrPulse),
    .ErrCnt        (ErrCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] flg;
    logic [3:0] abt;
    logic [3:0] idl;
    logic [3:0] ovf;
    logic       pls;
    logic [2:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation once its cycle has been reached.
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      cur = sbq.pop_front();
      checks++;
      if (cur.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", cur.name, cur.cyc,
                 cyc);
      end else if ({FlagErr, AbortErr, IdleErr, OvfErr, ErrPulse, ErrCnt} !==
                   {cur.flg, cur.abt, cur.idl, cur.ovf, cur.pls, cur.cnt}) begin
        errors++;
        $display("FAIL %s @%0d: got flag=%h abort=%h idle=%h ovf=%h pulse=%b cnt=%0d, want flag=%h abort=%h idle=%h ovf=%h pulse=%b cnt=%0d",
                 cur.name, cyc, FlagErr, AbortErr, IdleErr, OvfErr, ErrPulse, ErrCnt,
                 cur.flg, cur.abt, cur.idl, cur.ovf, cur.pls, cur.cnt);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushExp(input int dc, input string nm, input logic [3:0] f, input logic [3:0] a,
                         input logic [3:0] i, input logic [3:0] o, input logic p,
                         input logic [2:0] n);
    exp_t e;
    e.cyc  = base + dc;
    e.name = nm;
    e.flg  = f;
    e.abt  = a;
    e.idl  = i;
    e.ovf  = o;
    e.pls  = p;
    e.cnt  = n;
    sbq.push_back(e);
  endtask

  // 0,1x6,0 on one channel; the closing 0 is sampled on the 8th edge.
  task automatic driveFlagBits(input int ch);
    Rx[ch] = 1'b0;
    step();
    repeat (6) begin
      Rx[ch] = 1'b1;
      step();
    end
    Rx[ch] = 1'b0;
    step();
    Rx[ch] = 1'b1;
  endtask

  task automatic sendFlag(input int ch, input int det);
    driveFlagBits(ch);
    for (int k = 1; k <= 4; k++) begin
      Rx_FlagDetect[ch] = (k == det);
      step();
    end
    Rx_FlagDetect[ch] = 1'b0;
  endtask

  task automatic doClear(input string nm);
    base = cyc;
    pushExp(1, nm, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  initial begin
    step();
    step();
    base = cyc;
    pushExp(0, "reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    Rst = 1'b0;
    step();

    // Flag detected exactly FLAG_LAT edges after the closing 0.
    base = cyc;
    pushExp(10, "flag_ontime", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    pushExp(12, "flag_ontime_after", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    sendFlag(0, 2);

    // Detect one edge late.
    base = cyc;
    pushExp(10, "flag_late", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 3'd1);
    pushExp(11, "flag_late_pulse_end", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 3'd1);
    sendFlag(0, 3);

    doClear("clear_after_flag");

    // Abort qualified in frame, never signalled.
    base = cyc;
    pushExp(2, "abort_missed", 4'h0, 4'h2, 4'h0, 4'h0, 1'b1, 3'd1);
    pushExp(3, "abort_pulse_end", 4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 3'd1);
    Rx_AbortDetect[1] = 1'b1;
    Rx_ValidFrame[1]  = 1'b1;
    step();
    Rx_AbortDetect[1] = 1'b0;
    Rx_ValidFrame[1]  = 1'b0;
    step();
    step();

    // Out of frame: not qualified.
    base = cyc;
    pushExp(2, "abort_no_frame", 4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 3'd1);
    Rx_AbortDetect[1] = 1'b1;
    step();
    Rx_AbortDetect[1] = 1'b0;
    step();
    step();

    // Abort signalled on time.
    base = cyc;
    pushExp(2, "abort_ontime", 4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 3'd1);
    Rx_AbortDetect[2] = 1'b1;
    Rx_ValidFrame[2]  = 1'b1;
    step();
    Rx_AbortDetect[2] = 1'b0;
    Rx_ValidFrame[2]  = 1'b0;
    Rx_AbortSignal[2] = 1'b1;
    step();
    Rx_AbortSignal[2] = 1'b0;
    step();

    doClear("clear_after_abort");

    // Idle: counter at edge k is k-1, so only the 9th-edge zero is checked.
    base = cyc;
    pushExp(5, "idle_too_early", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    pushExp(9, "idle_low", 4'h0, 4'h0, 4'h8, 4'h0, 1'b1, 3'd1);
    pushExp(10, "idle_pulse_end", 4'h0, 4'h0, 4'h8, 4'h0, 1'b0, 3'd1);
    RxEN[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      Rx[3] = !(k == 5 || k == 9);
      step();
    end
    Rx[3]   = 1'b1;
    RxEN[3] = 1'b1;
    step();

    doClear("clear_after_idle");

    // Shared-zero back-to-back flags, no detect: two checks 7 edges apart.
    base = cyc;
    pushExp(10, "b2b_first", 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 3'd1);
    pushExp(11, "b2b_gap", 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 3'd1);
    pushExp(17, "b2b_second", 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 3'd2);
    driveFlagBits(1);
    repeat (6) step();
    Rx[1] = 1'b0;
    step();
    Rx[1] = 1'b1;
    repeat (3) step();

    doClear("clear_after_b2b");

    // All four channels miss an abort on two consecutive edges: 0 -> 4 -> 7 (saturated).
    base = cyc;
    pushExp(2, "sat_four", 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd4);
    pushExp(3, "sat_seven", 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd7);
    pushExp(4, "sat_hold", 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd7);
    Rx_AbortDetect = '1;
    Rx_ValidFrame  = '1;
    step();
    step();
    Rx_AbortDetect = '0;
    Rx_ValidFrame  = '0;
    step();
    step();

    // Clear on the same edge as a violation keeps that violation.
    base = cyc;
    pushExp(2, "clear_with_viol", 4'h0, 4'h1, 4'h0, 4'h0, 1'b1, 3'd1);
    pushExp(3, "clear_with_viol_after", 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 3'd1);
    Rx_AbortDetect[0] = 1'b1;
    Rx_ValidFrame[0]  = 1'b1;
    step();
    Rx_AbortDetect[0] = 1'b0;
    Rx_ValidFrame[0]  = 1'b0;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    step();

    // Overflow needs a concurrent write strobe.
    base = cyc;
    pushExp(1, "ovf_no_write", 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 3'd1);
    pushExp(2, "ovf_write", 4'h0, 4'h1, 4'h0, OvfExp, PulseOvf, CntAftOvf);
    pushExp(3, "ovf_after", 4'h0, 4'h1, 4'h0, OvfExp, 1'b0, CntAftOvf);
    Rx_Overflow[2] = 1'b1;
    step();
    Rx_WrBuff[2] = 1'b1;
    step();
    Rx_Overflow[2] = 1'b0;
    Rx_WrBuff[2]   = 1'b0;
    step();

    // Reset between a flag match and its check drops the pending check.
    base = cyc;
    pushExp(8, "pre_reset", 4'h0, 4'h1, 4'h0, OvfExp, 1'b0, CntAftOvf);
    pushExp(9, "reset_outputs", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    pushExp(10, "reset_drops_pending", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    pushExp(12, "reset_quiet", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
    driveFlagBits(1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    step();
    step();
    step();

    step();
    step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_monitor.md
# hdlc_rx_monitor

Synthesizable, multi-channel runtime protocol monitor for the HDLC receive path. It is the parametrised successor to the bench-only Rx concurrent checks and runs alongside one or more Rx channels in RTL or emulation. Per channel it checks three things: flag-detect latency, abort-signal latency, and idle-line level. It reports per-channel sticky error flags and a shared saturating error counter.

## Interface
- CHANNELS, 1, number of monitored Rx channels (1..8)
- FLAG_LAT, 2, cycles from last flag bit sampled to required Rx_FlagDetect (1..8)
- ABORT_LAT, 1, cycles from abort qualifier to required Rx_AbortSignal (1..8)
- IDLE_LEN, 8, consecutive disabled cycles before idle-level checking starts (1..255)
- CNT_W, 16, error counter width
- Clk  in  1  single clock; all inputs sampled and all state updated on posedge
- Rst  in  1  synchronous, active-high reset
- Clear  in  1  clears ErrCnt and sticky flags
- Rx  in  CHANNELS  serial Rx line per channel
- Rx_FlagDetect  in  CHANNELS  DUT flag-detect strobe
- Rx_ValidFrame  in  CHANNELS  DUT in-frame indication
- Rx_AbortDetect  in  CHANNELS  DUT abort-pattern detect
- Rx_AbortSignal  in  CHANNELS  DUT abort report
- Rx_Overflow  in  CHANNELS  DUT Rx buffer overflow
- Rx_WrBuff  in  CHANNELS  DUT Rx buffer write strobe
- TxEN  in  CHANNELS  Tx enable
- RxEN  in  CHANNELS  Rx enable
- FlagErr  out  CHANNELS  sticky: flag-latency violation seen
- AbortErr  out  CHANNELS  sticky: abort-latency violation seen
- IdleErr  out  CHANNELS  sticky: idle-level violation seen
- OvfErr  out  CHANNELS  sticky: overflow/write violation seen (see Configuration)
- ErrPulse  out  1  high for one cycle after any edge that records at least one violation
- ErrCnt  out  CNT_W  saturating total violation count

## Operation
- **Flag history.** Each channel keeps a 7-bit history of past Rx samples (hist[6] is oldest). Reset value is 7'h7F.
- **Flag match.** A match at an edge means {hist[6:0], Rx} == 8'b0111_1110. The all-ones reset value prevents a false match until a real leading 0 has been sampled.
- **Flag pending line.** A match loads bit 0 of a FLAG_LAT-deep pending shift line. The line shifts every edge, so overlapping matches are tracked independently.
- **Flag check.** A flag violation occurs when pending[FLAG_LAT-1] is set and Rx_FlagDetect is low.
- **Abort check.** Rx_AbortDetect && Rx_ValidFrame loads an ABORT_LAT-deep pending line. An abort violation occurs when its last stage is set and Rx_AbortSignal is low.
- **Idle counter.** A per-channel saturating 8-bit counter increments while !TxEN && !RxEN and clears to 0 when either enable is high.
- **Idle check.** An idle violation occurs on any edge where the counter is ≥ IDLE_LEN, both enables are still low, and Rx == 0. The idle line level is all ones.
- **Violation recording.** Each violation sets the matching sticky bit. ErrCnt adds the number of violations on that edge (0..4·CHANNELS) and saturates at 2^CNT_W−1.
- **Clear.** On a Clear edge, sticky bits load that edge's violations and ErrCnt loads that edge's violation count. Pending lines, history and idle counters are not affected by Clear.
- **Reset.** Rst has priority over Clear. It clears all pending lines, history (to 7'h7F), idle counters, sticky bits, ErrPulse and ErrCnt.

## Timing
- **Reset values.** All outputs are 0 after reset.
- **Flag latency.** Last flag bit sampled at edge t → Rx_FlagDetect must be high at edge t+FLAG_LAT. Violation outputs are visible after edge t+FLAG_LAT.
- **Abort latency.** Qualifier sampled at edge t → Rx_AbortSignal must be high at edge t+ABORT_LAT.
- **Output registration.** All outputs are registered, with no combinational input-to-output path.
- **Reset mid-check.** Rst asserted while a check is pending discards that check; no error is reported for it.
- **Back-to-back flags.** Shared-zero flags (0111111001111110) produce two independent checks 7 cycles apart.

## Configuration
- **HDLC_MON_OVERFLOW_CHK_EN defined.** An overflow violation occurs on any edge where Rx_Overflow && Rx_WrBuff. It sets OvfErr and counts in ErrCnt/ErrPulse.
- **Macro undefined.** OvfErr is tied to 0, no overflow logic is built, and the maximum per-edge increment is 3·CHANNELS.

## Test plan
- **Flag, correct latency.** CHANNELS=1, FLAG_LAT=2: drive 0,1×6,0 with Rx_FlagDetect high exactly 2 edges after the last 0 → FlagErr=0, ErrCnt=0.
- **Flag, late detect.** Same stimulus with Rx_FlagDetect high only at 3 edges → FlagErr=1, ErrCnt=1, ErrPulse high for one cycle.
- **Abort.** Pulse Rx_AbortDetect with Rx_ValidFrame=1 and hold Rx_AbortSignal low → AbortErr=1. Repeat with Rx_ValidFrame=0 → no new error.
- **Idle.** TxEN=RxEN=0 with Rx=0 on cycle 5, then on cycle 9 (IDLE_LEN=8) → only the cycle-9 sample errors: IdleErr=1, ErrCnt=1.
- **Simultaneous, saturating, Clear.** CHANNELS=4, CNT_W=3: four channels violating together → ErrCnt 0→4→7, where it saturates. Clear plus one violation on the same edge → ErrCnt=1. Rst → all outputs 0.
- **Overflow macro.** With HDLC_MON_OVERFLOW_CHK_EN: Rx_Overflow=Rx_WrBuff=1 for one edge → OvfErr=1, ErrCnt=1. Without the macro: OvfErr=0, ErrCnt=0.
